ball_physics: RTL and testbench

Downstream consumer of the accelerometer reader in the BallMaze design. Once per video frame it samples the signed X/Y tilt bytes, integrates them into a clamped ball velocity, and checks the candidate position against the screen border and the maze wall map. It then commits a new ball position for the renderer. Wall lookups use a req/ack handshake to the maze map block, so map latency is arbitrary.

---
 rtl/ball_physics.sv | 173 +++++++++++++++++
 tb/tb_ball_physics.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_physics.sv
// Per-frame ball integrator: tilt -> clamped velocity -> border/wall-checked position.
// Optional BALL_FRICTION_EN: a zero-acceleration axis decays its velocity by 1 toward 0.
module ball_physics #(
   parameter int SCREEN_W  = 640,
   parameter int SCREEN_H  = 480,
   parameter int BALL_SIZE = 8,
   parameter int START_X   = 16,
   parameter int START_Y   = 16,
   parameter int DEAD_ZONE = 4,
   parameter int SHIFT     = 3,
   parameter int VMAX      = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic [7:0] x_tilt,
   input  logic [7:0] y_tilt,
   output logic       q_req,
   output logic [9:0] q_x,
   output logic [9:0] q_y,
   input  logic       q_ack,
   input  logic       q_hit,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic       busy,
   output logic       upd_done,
   output logic [2:0] dbg_state
);

   // Map handshake: q_req is a one-cycle strobe; q_x/q_y stay put until the single-cycle
   // q_ack (with q_hit) is seen in the matching wait state. Acks elsewhere are ignored.
   typedef enum logic [2:0] {IDLE, ACCEL, PROBE_X, WAIT_X, PROBE_Y, WAIT_Y, COMMIT} state_t;

   localparam logic signed [7:0]  DZ_P    = 8'(DEAD_ZONE);
   localparam logic signed [7:0]  DZ_N    = -DZ_P;
   localparam logic signed [8:0]  V_P     = 9'(VMAX);
   localparam logic signed [8:0]  V_N     = -V_P;
   localparam logic signed [10:0] LIM_X   = 11'(SCREEN_W - BALL_SIZE);
   localparam logic signed [10:0] LIM_Y   = 11'(SCREEN_H - BALL_SIZE);
   localparam logic [9:0]         START_XP = 10'(START_X);
   localparam logic [9:0]         START_YP = 10'(START_Y);

   state_t            state, state_n;
   logic signed [7:0] tx, ty;
   logic signed [5:0] vx, vy, vx_acc, vy_acc;
   logic [9:0]        fx, fy, cx, cy;
   logic              cx_clamp, cy_clamp;

   function automatic logic signed [5:0] next_vel(input logic signed [5:0] v,
                                                  input logic signed [7:0] t);
      logic signed [7:0] a;
      logic signed [8:0] s;
      a = (t > DZ_P || t < DZ_N) ? (t >>> SHIFT) : 8'sd0;
      s = {{3{v[5]}}, v} + {a[7], a};
`ifdef BALL_FRICTION_EN
      if (a == 8'sd0) begin
         if (v > 6'sd0)
            s = s - 9'sd1;
         else if (v < 6'sd0)
            s = s + 9'sd1;
      end
`endif
      if (s > V_P)
         next_vel = V_P[5:0];
      else if (s < V_N)
         next_vel = V_N[5:0];
      else
         next_vel = s[5:0];
   endfunction

   // Returns {clamped, position}; the flag tells the caller to zero that axis velocity.
   function automatic logic [10:0] clamp_pos(input logic [9:0] p,
                                             input logic signed [5:0] v,
                                             input logic signed [10:0] lim);
      logic signed [10:0] s;
      s = {1'b0, p} + {{5{v[5]}}, v};
      if (s < 11'sd0)
         clamp_pos = {1'b1, 10'd0};
      else if (s > lim)
         clamp_pos = {1'b1, lim[9:0]};
      else
         clamp_pos = {1'b0, s[9:0]};
   endfunction

   always_comb begin
      vx_acc = next_vel(vx, tx);
      vy_acc = next_vel(vy, ty);
      {cx_clamp, cx} = clamp_pos(ball_x, vx_acc, LIM_X);
      {cy_clamp, cy} = clamp_pos(ball_y, vy, LIM_Y);
   end

   always_comb begin
      state_n   = state;
      busy      = (state != IDLE);
      q_req     = 1'b0;
      dbg_state = state;
      case (state)
         IDLE:    if (frame_tick) state_n = ACCEL;
         ACCEL:   state_n = PROBE_X;
         PROBE_X: begin
            q_req   = 1'b1;
            state_n = WAIT_X;
         end
         WAIT_X:  if (q_ack) state_n = PROBE_Y;
         PROBE_Y: begin
            q_req   = 1'b1;
            state_n = WAIT_Y;
         end
         WAIT_Y:  if (q_ack) state_n = COMMIT;
         COMMIT:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Probe coordinates are loaded on entry to each PROBE state so they are valid with q_req.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         tx       <= 8'sd0;
         ty       <= 8'sd0;
         vx       <= 6'sd0;
         vy       <= 6'sd0;
         fx       <= START_XP;
         fy       <= START_YP;
         q_x      <= 10'd0;
         q_y      <= 10'd0;
         ball_x   <= START_XP;
         ball_y   <= START_YP;
         upd_done <= 1'b0;
      end else begin
         state    <= state_n;
         upd_done <= 1'b0;
         case (state)
            IDLE: if (frame_tick) begin
               tx <= x_tilt;
               ty <= y_tilt;
            end
            ACCEL: begin
               vx  <= cx_clamp ? 6'sd0 : vx_acc;
               vy  <= vy_acc;
               q_x <= cx;
               q_y <= ball_y;
            end
            WAIT_X: if (q_ack) begin
               if (q_hit) begin
                  fx  <= ball_x;
                  q_x <= ball_x;
                  vx  <= 6'sd0;
               end else begin
                  fx  <= q_x;
               end
               vy  <= cy_clamp ? 6'sd0 : vy;
               q_y <= cy;
            end
            WAIT_Y: if (q_ack) begin
               if (q_hit) begin
                  fy <= ball_y;
                  vy <= 6'sd0;
               end else begin
                  fy <= q_y;
               end
            end
            COMMIT: begin
               ball_x   <= fx;
               ball_y   <= fy;
               upd_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ball_physics.sv
// Bench for ball_physics: frame-level reference model, probe/commit scoreboard, random map.
// Build with BALL_FRICTION_EN defined to check the friction variant.
module tb_ball_physics;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_tick;
   logic [7:0] x_tilt, y_tilt;
   logic       q_req, q_ack, q_hit;
   logic [9:0] q_x, q_y, ball_x, ball_y;
   logic       busy, upd_done;
   logic [2:0] dbg_state;
   logic       rsp_ack, man_ack, rsp_hit;

   assign q_ack = rsp_ack | man_ack;
   assign q_hit = rsp_hit;

   ball_physics dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick),
      .x_tilt(x_tilt), .y_tilt(y_tilt),
      .q_req(q_req), .q_x(q_x), .q_y(q_y), .q_ack(q_ack), .q_hit(q_hit),
      .ball_x(ball_x), .ball_y(ball_y), .busy(busy), .upd_done(upd_done),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [19:0] exp_q[$];
   logic [19:0] probe_q[$];
   logic [19:0] cur_exp;
   bit chk_en = 0;
   bit rsp_en = 1;
   bit cur_hx, cur_hy;
   int cur_lat = 0;
   int m_bx, m_by, m_vx, m_vy;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (one call per accepted frame) ----------------
   function automatic int sat(input int v);
      return (v > 15) ? 15 : (v < -15) ? -15 : v;
   endfunction

   function automatic int step_vel(input int v, input logic [7:0] t);
      int ti, a, n;
      ti = int'($signed(t));
      a = (ti > 4 || ti < -4) ? (ti >>> 3) : 0;
      n = v + a;
`ifdef BALL_FRICTION_EN
      if (a == 0) n = (v > 0) ? v - 1 : (v < 0) ? v + 1 : v;
`endif
      return sat(n);
   endfunction

   task automatic model_frame(input logic [7:0] tx, ty, input bit hx, hy);
      int cx, cy, fx, fy;
      m_vx = step_vel(m_vx, tx);
      m_vy = step_vel(m_vy, ty);
      cx = m_bx + m_vx;
      if (cx < 0) begin cx = 0; m_vx = 0; end
      else if (cx > 632) begin cx = 632; m_vx = 0; end
      probe_q.push_back({10'(cx), 10'(m_by)});
      if (hx) begin fx = m_bx; m_vx = 0; end else fx = cx;
      cy = m_by + m_vy;
      if (cy < 0) begin cy = 0; m_vy = 0; end
      else if (cy > 472) begin cy = 472; m_vy = 0; end
      probe_q.push_back({10'(fx), 10'(cy)});
      if (hy) begin fy = m_by; m_vy = 0; end else fy = cy;
      m_bx = fx;
      m_by = fy;
      exp_q.push_back({10'(fx), 10'(fy)});
   endtask

   // ---------------- scoreboard: probes, commits, position hold ----------------
   always @(negedge clk) begin
      logic [19:0] e;
      if (chk_en) begin
         if (q_req) begin
            if (probe_q.size() == 0) begin
               total++; bad++;
               $display("FAIL probe_extra: got q_req at %h expected none", {q_x, q_y});
            end else begin
               e = probe_q.pop_front();
               check("probe_xy", {12'd0, q_x, q_y}, {12'd0, e});
            end
         end
         if (upd_done) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL commit_extra: got upd_done at %h expected none", {ball_x, ball_y});
            end else begin
               cur_exp = exp_q.pop_front();
            end
         end
         check("ball_pos", {12'd0, ball_x, ball_y}, {12'd0, cur_exp});
      end
   end

   // ---------------- map responder ----------------
   initial begin
      int qcnt;
      logic [9:0] px, py;
      bit h;
      qcnt = 0;
      rsp_ack = 1'b0;
      rsp_hit = 1'b0;
      forever begin
         @(negedge clk);
         if (rsp_en && q_req) begin
            px = q_x;
            py = q_y;
            h = qcnt[0] ? cur_hy : cur_hx;
            qcnt++;
            @(posedge clk); #1;
            for (int i = 0; i < cur_lat; i++) begin
               check("q_hold", {12'd0, q_x, q_y}, {12'd0, px, py});
               @(posedge clk); #1;
            end
            check("q_hold", {12'd0, q_x, q_y}, {12'd0, px, py});
            rsp_ack = 1'b1;
            rsp_hit = h;
            @(posedge clk); #1;
            rsp_ack = 1'b0;
            rsp_hit = 1'($urandom_range(0, 1));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      chk_en = 0;
      reset = 1'b0;
      frame_tick = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      exp_q.delete();
      probe_q.delete();
      m_bx = 16; m_by = 16; m_vx = 0; m_vy = 0;
      cur_exp = {10'd16, 10'd16};
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst_ball_x", ball_x, 16);
      check("rst_ball_y", ball_y, 16);
      check("rst_busy", busy, 0);
      check("rst_q_req", q_req, 0);
      check("rst_q_xy", {q_x, q_y}, 0);
      check("rst_upd_done", upd_done, 0);
      chk_en = 1;
   endtask

   // mode 0: clean; 1: extra tick while waiting on the map; 2: extra tick in COMMIT cycle
   task automatic do_frame(input logic [7:0] tx, ty, input bit hx, hy, input int lat, mode);
      int n;
      n = 6 + 2 * lat;
      cur_hx = hx; cur_hy = hy; cur_lat = lat;
      model_frame(tx, ty, hx, hy);
      frame_tick = 1'b1;
      x_tilt = tx;
      y_tilt = ty;
      @(posedge clk); #1;
      frame_tick = 1'b0;
      x_tilt = 8'($urandom_range(0, 255));
      y_tilt = 8'($urandom_range(0, 255));
      for (int c = 0; c <= n; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         frame_tick = (mode == 1 && c == 2) || (mode == 2 && c == n - 1);
         check("busy", busy, 32'(c < n));
         check("upd_done", upd_done, 32'(c == n));
      end
      frame_tick = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      frame_tick = 1'b0;
      x_tilt = 8'd0;
      y_tilt = 8'd0;
      man_ack = 1'b0;

      // Rest frame, then steady push right with velocity saturation.
      do_reset();
      do_frame(8'h00, 8'h00, 0, 0, 0, 0);
      check("rest_x", ball_x, 16);
      check("rest_y", ball_y, 16);
      do_frame(8'h40, 8'h00, 0, 0, 0, 0);
      check("push1_x", ball_x, 24);
      do_frame(8'h40, 8'h00, 0, 0, 1, 0);
      check("push2_x", ball_x, 39);
      do_frame(8'h40, 8'h00, 0, 0, 0, 0);
      check("push3_x", ball_x, 54);
      check("push3_y", ball_y, 16);

      // Drive into the right border, then back off to prove the clamp zeroed vx.
      repeat (40) do_frame(8'h40, 8'h00, 0, 0, 0, 0);
      check("border_x", ball_x, 632);
      do_frame(8'hC0, 8'h00, 0, 0, 0, 0);
      check("after_border_x", ball_x, 624);

      // Dead zone with a prior velocity of 5.
      do_reset();
      do_frame(8'h28, 8'h00, 0, 0, 0, 0);
      check("v5_x", ball_x, 21);
      do_frame(8'h03, 8'h00, 0, 0, 0, 0);
`ifdef BALL_FRICTION_EN
      check("deadzone_x", ball_x, 25);
`else
      check("deadzone_x", ball_x, 26);
`endif

      // X wall hit: X held, Y still moves.
      do_reset();
      do_frame(8'h40, 8'h40, 0, 0, 0, 0);
      check("diag_xy", {ball_x, ball_y}, {10'd24, 10'd24});
      do_frame(8'h00, 8'h00, 1, 0, 0, 0);
`ifdef BALL_FRICTION_EN
      check("xhit_xy", {ball_x, ball_y}, {10'd24, 10'd31});
`else
      check("xhit_xy", {ball_x, ball_y}, {10'd24, 10'd32});
`endif

      // Slow map with a tick while busy; tick in COMMIT; then back-to-back frame.
      do_reset();
      do_frame(8'h40, 8'h40, 0, 0, 10, 1);
      check("slow_xy", {ball_x, ball_y}, {10'd24, 10'd24});
      do_frame(8'h00, 8'hC0, 0, 0, 0, 2);
      do_frame(8'h00, 8'h00, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("no_extra_done", upd_done, 0);
      end

      // Reset in the middle of an update, then a stray ack.
      chk_en = 0;
      rsp_en = 0;
      frame_tick = 1'b1;
      x_tilt = 8'h40;
      y_tilt = 8'h40;
      @(posedge clk); #1;
      frame_tick = 1'b0;
      @(posedge clk); #1;
      check("abort_q_req", q_req, 1);
      @(posedge clk); #1;
      check("abort_busy", busy, 1);
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      check("abort_q_req_off", q_req, 0);
      check("abort_idle", busy, 0);
      man_ack = 1'b1;
      @(posedge clk); #1;
      man_ack = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check("late_ack_done", upd_done, 0);
         check("late_ack_busy", busy, 0);
         check("late_ack_pos", {ball_x, ball_y}, {10'd16, 10'd16});
         @(posedge clk); #1;
      end
      rsp_en = 1;
      m_bx = 16; m_by = 16; m_vx = 0; m_vy = 0;
      cur_exp = {10'd16, 10'd16};
      chk_en = 1;

      // Randomized frames: full tilt range, random hits, latency and stray ticks.
      for (int f = 0; f < 80; f++) begin
         do_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 3), $urandom_range(0, 2));
      end

      repeat (5) begin @(posedge clk); #1; end
      check("exp_q_drained", exp_q.size(), 0);
      check("probe_q_drained", probe_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
